// File: rtl/btn_pkg.sv
// Shared types and constants for the four-button debouncer.
// Optional auto-repeat is enabled with BTN_DEBOUNCE_REPEAT_EN.
package btn_pkg;

    typedef logic [1:0] btn_state_t;

    localparam btn_state_t IDLE       = 2'd0;
    localparam btn_state_t PRESS_WAIT = 2'd1;
    localparam btn_state_t HELD       = 2'd2;
    localparam btn_state_t REL_WAIT   = 2'd3;

    localparam int BTN_IDX_NORTH = 0;
    localparam int BTN_IDX_SOUTH = 1;
    localparam int BTN_IDX_WEST  = 2;
    localparam int BTN_IDX_EAST  = 3;

    function automatic int unsigned max2(input int unsigned a,
                                         input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM, optional
// auto-repeat (BTN_DEBOUNCE_REPEAT_EN).
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync1_d;
    logic            sync_q, sync_d;
    btn_state_t      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;

`ifdef BTN_DEBOUNCE_REPEAT_EN
    localparam int RW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_first_q, rep_first_d;
    logic [RW-1:0] rep_target;

    assign rep_target = rep_first_q ? REP_FIRST : REP_NEXT;
`endif

    always_comb begin
        sync1_d   = btn_raw;
        sync_d    = sync1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
`ifdef BTN_DEBOUNCE_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
`endif
        case (state_q)
            IDLE: begin
                if (sync_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!sync_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
`ifdef BTN_DEBOUNCE_REPEAT_EN
                    rep_cnt_d   = '0;
                    rep_first_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HELD: begin
                if (!sync_q) begin
                    state_d = REL_WAIT;
                    cnt_d   = CW'(1);
`ifdef BTN_DEBOUNCE_REPEAT_EN
                    rep_cnt_d = '0;
                end else if (rep_cnt_q == rep_target) begin
                    press_d     = 1'b1;
                    rep_cnt_d   = '0;
                    rep_first_d = 1'b0;
                end else begin
                    rep_cnt_d = rep_cnt_q + RW'(1);
`endif
                end
            end
            REL_WAIT: begin
                if (sync_q) begin
                    // bounce during release: resume hold, no pulse
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync_q    <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

`ifdef BTN_DEBOUNCE_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
        end
    end
`endif

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/btn_debounce.sv
// Four-button debouncer feeding the LCD controller button inputs.
// Define BTN_DEBOUNCE_REPEAT_EN to enable press auto-repeat.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       BTN_NORTH,
    input  logic       BTN_SOUTH,
    input  logic       BTN_WEST,
    input  logic       BTN_EAST,
    output logic [3:0] btn_level,
    output logic [3:0] btn_press,
    output logic [3:0] btn_release
);

    logic [3:0] btn_raw;

    assign btn_raw[BTN_IDX_NORTH] = BTN_NORTH;
    assign btn_raw[BTN_IDX_SOUTH] = BTN_SOUTH;
    assign btn_raw[BTN_IDX_WEST]  = BTN_WEST;
    assign btn_raw[BTN_IDX_EAST]  = BTN_EAST;

    for (genvar i = 0; i < 4; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .btn_raw  (btn_raw[i]),
            .level_o  (btn_level[i]),
            .press_o  (btn_press[i]),
            .release_o(btn_release[i])
        );
    end

endmodule
